digi_ota_array: RTL and testbench

DIGI_OTA_ARRAY -- requirements
Module: digi_ota_array

---
 rtl/digi_ota_array.sv | 99 +++++++++
 tb/tb_digi_ota_array.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/digi_ota_array.sv
`default_nettype none
// ============================================================================
// Module      : digi_ota_array
// Description : Array of digital OTA channels. Each channel synchronizes its
//               vip/vin pair, filters the derived drive candidate and commits
//               it to a tri-state output (HIZ / DRV_HI / DRV_LO).
// Revision    : 1.0 - initial release
// ============================================================================
module digi_ota_array #(
    parameter int CH   = 4,
    parameter int FILT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode,
    input  logic [CH-1:0] vip,
    input  logic [CH-1:0] vin,
    output logic [CH-1:0] out_val,
    output logic [CH-1:0] out_oe,
    output logic [CH-1:0] chg,
    output logic          any_active
);

    localparam logic [1:0] ST_HIZ    = 2'b00;
    localparam logic [1:0] ST_DRV_HI = 2'b01;
    localparam logic [1:0] ST_DRV_LO = 2'b10;

    localparam logic [3:0] C_CMAX = 4'(FILT - 1);

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic       r_s1_vip, r_s1_vin;
            logic       r_s2_vip, r_s2_vin;
            logic [1:0] w_cand;
            logic [1:0] r_p;
            logic [3:0] r_c;
            logic [1:0] r_state;
            logic [1:0] w_state_nxt;
            logic       r_chg;

            always_comb begin
                w_cand = ST_HIZ;
                if (r_s2_vip != r_s2_vin) begin
                    w_cand = r_s2_vip ? ST_DRV_HI : ST_DRV_LO;
                end
            end

            // Latch mode only blocks a drive-to-HIZ release; drive reversals still commit.
            always_comb begin
                w_state_nxt = r_state;
                if (!en) begin
                    w_state_nxt = ST_HIZ;
                end else if ((w_cand == r_p) && (r_c == C_CMAX) && (r_p != r_state)) begin
                    if (!(mode && (r_state != ST_HIZ) && (r_p == ST_HIZ))) begin
                        w_state_nxt = r_p;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_vip <= 1'b0;
                    r_s1_vin <= 1'b0;
                    r_s2_vip <= 1'b0;
                    r_s2_vin <= 1'b0;
                    r_p      <= ST_HIZ;
                    r_c      <= 4'd0;
                    r_state  <= ST_HIZ;
                    r_chg    <= 1'b0;
                end else begin
                    r_s1_vip <= vip[i];
                    r_s1_vin <= vin[i];
                    r_s2_vip <= r_s1_vip;
                    r_s2_vin <= r_s1_vin;
                    if (!en) begin
                        r_p <= ST_HIZ;
                        r_c <= 4'd0;
                    end else if (w_cand != r_p) begin
                        r_p <= w_cand;
                        r_c <= 4'd0;
                    end else if (r_c < C_CMAX) begin
                        r_c <= r_c + 4'd1;
                    end
                    r_state <= w_state_nxt;
                    r_chg   <= (w_state_nxt != r_state);
                end
            end

            assign out_oe[i]  = (r_state != ST_HIZ);
            assign out_val[i] = (r_state == ST_DRV_HI);
            assign chg[i]     = r_chg;
        end
    endgenerate

    assign any_active = |out_oe;

endmodule
`default_nettype wire

// File: tb/tb_digi_ota_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_digi_ota_array
// Description : Directed self-checking bench for digi_ota_array (CH=4, FILT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digi_ota_array;

    localparam int CH   = 4;
    localparam int FILT = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic          mode;
    logic [CH-1:0] vip;
    logic [CH-1:0] vin;
    logic [CH-1:0] out_val;
    logic [CH-1:0] out_oe;
    logic [CH-1:0] chg;
    logic          any_active;

    int            n_cmp;
    int            n_err;
    logic [CH-1:0] seen_chg;
    logic [CH-1:0] seen_oe;

    digi_ota_array #(.CH(CH), .FILT(FILT)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .vip        (vip),
        .vin        (vin),
        .out_val    (out_val),
        .out_oe     (out_oe),
        .chg        (chg),
        .any_active (any_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample 1 ns later; track any chg/oe activity.
    task automatic tick();
        @(posedge clk);
        #1;
        seen_chg = seen_chg | chg;
        seen_oe  = seen_oe | out_oe;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        seen_chg = '0;
        seen_oe  = '0;
        rst      = 1'b1;
        en       = 1'b1;
        mode     = 1'($urandom_range(0, 1));
        vip      = 4'($urandom);
        vin      = 4'($urandom);

        // Reset with random inputs
        tick();
        tick();
        chk("rst_oe",  8'(out_oe),     8'h0);
        chk("rst_val", 8'(out_val),    8'h0);
        chk("rst_chg", 8'(chg),        8'h0);
        chk("rst_any", 8'(any_active), 8'h0);

        rst  = 1'b0;
        mode = 1'b0;
        vip  = 4'b0000;
        vin  = 4'b0000;
        tick();
        chk("post_rst_oe",  8'(out_oe),     8'h0);
        chk("post_rst_any", 8'(any_active), 8'h0);
        repeat (4) tick();

        // Channel 0 drive high: commit on the 6th edge
        vip[0] = 1'b1;
        repeat (5) tick();
        chk("a_edge5_oe", 8'(out_oe), 8'h0);
        tick();
        chk("a_edge6_oe",  8'(out_oe),     8'h1);
        chk("a_edge6_val", 8'(out_val),    8'h1);
        chk("a_edge6_chg", 8'(chg),        8'h1);
        chk("a_edge6_any", 8'(any_active), 8'h1);
        tick();
        chk("a_edge7_chg", 8'(chg), 8'h0);

        // Channel 1 glitch of 2 cycles must be filtered out
        seen_chg = '0;
        seen_oe  = '0;
        vip[1]   = 1'b1;
        tick();
        tick();
        vip[1] = 1'b0;
        repeat (8) tick();
        chk("b_glitch_chg", 8'(seen_chg & 4'b0010), 8'h0);
        chk("b_glitch_oe",  8'(seen_oe & 4'b0010),  8'h0);

        // Channel 1 pulse long enough to qualify (p load + FILT-1 counts + commit)
        vip[1] = 1'b1;
        repeat (4) tick();
        vip[1] = 1'b0;
        tick();
        tick();
        chk("b_commit_oe",  8'(out_oe), 8'h3);
        chk("b_commit_chg", 8'(chg),    8'h2);
        repeat (3) tick();
        chk("b_hold_oe", 8'(out_oe), 8'h3);
        tick();
        chk("b_release_oe",  8'(out_oe), 8'h1);
        chk("b_release_chg", 8'(chg),    8'h2);

        // Channel 2 drive low, then latch mode holds it against a HIZ candidate
        vin[2] = 1'b1;
        repeat (6) tick();
        chk("c_lo_oe",  8'(out_oe),  8'h5);
        chk("c_lo_val", 8'(out_val), 8'h1);
        chk("c_lo_chg", 8'(chg),     8'h4);
        mode     = 1'b1;
        vip[2]   = 1'b1;
        seen_chg = '0;
        repeat (8) tick();
        chk("c_latch_oe",  8'(out_oe),   8'h5);
        chk("c_latch_val", 8'(out_val),  8'h1);
        chk("c_latch_chg", 8'(seen_chg), 8'h0);
        mode = 1'b0;
        tick();
        chk("c_follow_oe",  8'(out_oe), 8'h1);
        chk("c_follow_chg", 8'(chg),    8'h4);

        // Channels 0 and 3 driving, then en drop and re-qualification
        vip[3] = 1'b1;
        repeat (6) tick();
        chk("d_drive_oe",  8'(out_oe), 8'h9);
        chk("d_drive_chg", 8'(chg),    8'h8);
        en = 1'b0;
        tick();
        chk("d_en0_oe",  8'(out_oe),     8'h0);
        chk("d_en0_chg", 8'(chg),        8'h9);
        chk("d_en0_any", 8'(any_active), 8'h0);
        tick();
        chk("d_en0_chg2", 8'(chg), 8'h0);
        en = 1'b1;
        repeat (3) tick();
        chk("d_en1_e3_oe", 8'(out_oe), 8'h0);
        tick();
        chk("d_en1_e4_oe",  8'(out_oe), 8'h9);
        chk("d_en1_e4_chg", 8'(chg),    8'h9);

        // Reset while ch1 is mid-qualification and ch0/ch3 are driving
        vip[1] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("e_rst_oe",  8'(out_oe),     8'h0);
        chk("e_rst_val", 8'(out_val),    8'h0);
        chk("e_rst_chg", 8'(chg),        8'h0);
        chk("e_rst_any", 8'(any_active), 8'h0);
        rst      = 1'b0;
        seen_chg = '0;
        repeat (5) tick();
        chk("e_edge5_oe",  8'(out_oe),   8'h0);
        chk("e_edge5_chg", 8'(seen_chg), 8'h0);
        tick();
        chk("e_edge6_oe",  8'(out_oe),  8'hB);
        chk("e_edge6_val", 8'(out_val), 8'hB);
        chk("e_edge6_chg", 8'(chg),     8'hB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
